// File: rtl/lgn_frame_loader_if.sv
// Pixel stream handshake between a grayscale source (master) and the frame loader (slave).
// A pixel is transferred on any rising edge where pix_valid and pix_ready are both high.
interface lgn_frame_loader_if;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_data;
    logic       pix_last;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_last,
        output pix_ready
    );
endinterface

// File: rtl/lgn_frame_loader.sv
// Binarizes a grayscale frame into MSB-first packed bytes for the classifier, then waits a
// short settle time and captures the classifier's combinational result.
module lgn_frame_loader #(
    parameter int PIXELS        = 784,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    lgn_frame_loader_if.slave   pix,
    input  logic [7:0]          threshold,
    output logic [7:0]          out_byte,
    output logic                out_we,
    input  logic [15:0]         result_in,
    output logic [15:0]         result,
    output logic                result_valid,
    output logic                frame_error,
    output logic                busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] SKIP   = 2'd2;
    localparam logic [1:0] SETTLE = 2'd3;

    localparam logic [9:0] LAST_IDX    = 10'(PIXELS - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state;
    logic [9:0] pix_cnt;
    logic [3:0] settle_cnt;
    logic [6:0] shift;
    logic       accept;
    logic       pix_bit;
    logic       at_last_idx;
    logic [7:0] packed_byte;

    assign pix.pix_ready = (state != SETTLE);
    assign busy          = (state != IDLE);
    assign accept        = pix.pix_valid & pix.pix_ready;
    assign pix_bit       = (pix.pix_data >= threshold);
    assign packed_byte   = {shift, pix_bit};
    assign at_last_idx   = (pix_cnt == LAST_IDX);

    // The pixel counter is only ever nonzero in LOAD, so IDLE always treats its pixel as index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pix_cnt      <= '0;
            settle_cnt   <= '0;
            shift        <= '0;
            out_byte     <= '0;
            out_we       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            out_we       <= 1'b0;
            result_valid <= 1'b0;
            frame_error  <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    if (accept) begin
                        shift <= packed_byte[6:0];
                        if (pix.pix_last && !at_last_idx) begin
                            frame_error <= 1'b1;
                            pix_cnt     <= '0;
                            state       <= IDLE;
                        end else begin
                            if (pix_cnt[2:0] == 3'd7) begin
                                out_byte <= packed_byte;
                                out_we   <= 1'b1;
                            end
                            if (at_last_idx) begin
                                pix_cnt    <= '0;
                                settle_cnt <= '0;
                                if (pix.pix_last) begin
                                    state <= SETTLE;
                                end else begin
                                    frame_error <= 1'b1;
                                    state       <= SKIP;
                                end
                            end else begin
                                pix_cnt <= pix_cnt + 10'd1;
                                state   <= LOAD;
                            end
                        end
                    end
                end
                SKIP: begin
                    if (accept && pix.pix_last) begin
                        state <= IDLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        result       <= result_in;
                        result_valid <= 1'b1;
                        settle_cnt   <= '0;
                        state        <= IDLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lgn_frame_loader.sv
// Self-checking bench for lgn_frame_loader: expected bytes and results are queued as pixels are
// driven and popped by a monitor when the loader strobes out_we or result_valid.
module tb_lgn_frame_loader;

    typedef struct {
        logic [63:0] pix;
        logic [7:0]  thr;
        logic [7:0]  exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  threshold;
    logic [7:0]  out_byte;
    logic        out_we;
    logic [15:0] result_in;
    logic [15:0] result;
    logic        result_valid;
    logic        frame_error;
    logic        busy;

    lgn_frame_loader_if pix_if ();

    lgn_frame_loader #(
        .PIXELS        (784),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix          (pix_if.slave),
        .threshold    (threshold),
        .out_byte     (out_byte),
        .out_we       (out_we),
        .result_in    (result_in),
        .result       (result),
        .result_valid (result_valid),
        .frame_error  (frame_error),
        .busy         (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] res_q[$];
    logic [7:0]  exp_b;
    logic [15:0] exp_r;

    int  cycle         = 0;
    int  last_we_cycle = -1;
    int  we_count      = 0;
    int  rv_count      = 0;
    int  fe_count      = 0;
    int  ready_low     = 0;
    bit  check_spacing = 0;
    bit  gaps          = 0;

    vec_t vecs[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard side: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            cycle++;
            if (!pix_if.pix_ready) ready_low++;
            if (frame_error) fe_count++;
            if (out_we) begin
                we_count++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_write out_byte=%h required no write", out_byte);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (out_byte !== exp_b) begin
                        miscompares++;
                        $display("[TB] FAIL out_byte actual=%h required=%h", out_byte, exp_b);
                    end
                end
                if (check_spacing && last_we_cycle >= 0) begin
                    vectors++;
                    if (cycle - last_we_cycle != 8) begin
                        miscompares++;
                        $display("[TB] FAIL we_spacing actual=%0d required=8", cycle - last_we_cycle);
                    end
                end
                last_we_cycle = cycle;
            end
            if (result_valid) begin
                rv_count++;
                vectors++;
                if (res_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_result result=%h required no result", result);
                end else begin
                    exp_r = res_q.pop_front();
                    if (result !== exp_r) begin
                        miscompares++;
                        $display("[TB] FAIL result actual=%h required=%h", result, exp_r);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Offers one pixel starting at a falling edge and returns at the falling edge after acceptance.
    task automatic send_pixel(input logic [7:0] d, input logic [7:0] thr, input logic l);
        int guard;
        if (gaps) begin
            while ($urandom_range(1) == 0) begin
                pix_if.pix_valid = 1'b0;
                pix_if.pix_data  = 8'($urandom);
                pix_if.pix_last  = 1'($urandom);
                threshold        = 8'($urandom);
                @(negedge clk);
            end
        end
        pix_if.pix_valid = 1'b1;
        pix_if.pix_data  = d;
        pix_if.pix_last  = l;
        threshold        = thr;
        guard = 0;
        while (!pix_if.pix_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            miscompares++;
            $display("[TB] FAIL ready_timeout actual=0 required=1");
        end
        @(negedge clk);
        pix_if.pix_valid = 1'b0;
        pix_if.pix_last  = 1'b0;
    endtask

    task automatic applyStimulus(input logic [63:0] pix8, input logic [7:0] thr,
                                 input logic [7:0] exp, input logic last_on_8th);
        exp_q.push_back(exp);
        for (int i = 0; i < 8; i++) begin
            send_pixel(pix8[63 - 8*i -: 8], thr, last_on_8th && (i == 7));
        end
    endtask

    task automatic clear_counters();
        we_count      = 0;
        rv_count      = 0;
        fe_count      = 0;
        ready_low     = 0;
        last_we_cycle = -1;
    endtask

    task automatic end_frame(input string name, input int exp_we, input int exp_rv,
                             input int exp_fe, input int exp_rdy_low);
        int guard;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            miscompares++;
            $display("[TB] FAIL %s_idle_timeout busy=%0d required=0", name, busy);
        end
        repeat (3) @(negedge clk);
        checkOutput({name, "_writes"},       32'(we_count),     32'(exp_we));
        checkOutput({name, "_results"},      32'(rv_count),     32'(exp_rv));
        checkOutput({name, "_frame_errors"}, 32'(fe_count),     32'(exp_fe));
        checkOutput({name, "_ready_low"},    32'(ready_low),    32'(exp_rdy_low));
        checkOutput({name, "_byte_q"},       32'(exp_q.size()), 32'd0);
        checkOutput({name, "_result_q"},     32'(res_q.size()), 32'd0);
        checkOutput({name, "_busy"},         32'(busy),         32'd0);
        clear_counters();
    endtask

    task automatic nominal_frame(input logic [15:0] res_val);
        result_in = res_val;
        res_q.push_back(res_val);
        for (int b = 0; b < 98; b++) begin
            applyStimulus(64'hC80AC80AC80AC80A, 8'd128, 8'hAA, b == 97);
        end
    endtask

    initial begin
        vecs[0] = '{pix: 64'h807F7F7F7F7F7F7F, thr: 8'h80, exp: 8'h80};
        vecs[1] = '{pix: 64'h7F7F7F7F7F7F7F7F, thr: 8'h80, exp: 8'h00};
        vecs[2] = '{pix: 64'h8080808080808080, thr: 8'h80, exp: 8'hFF};
        vecs[3] = '{pix: 64'h0000000000000000, thr: 8'h00, exp: 8'hFF};
        vecs[4] = '{pix: 64'hFFFEFFFEFFFEFFFE, thr: 8'hFF, exp: 8'hAA};
        vecs[5] = '{pix: 64'h0102030405060708, thr: 8'h05, exp: 8'h0F};
        vecs[6] = '{pix: 64'hC80AC80AC80AC80A, thr: 8'hC9, exp: 8'h00};
        vecs[7] = '{pix: 64'hC80AC80AC80AC80A, thr: 8'h0B, exp: 8'hAA};

        rst_n            = 1'b0;
        pix_if.pix_valid = 1'b0;
        pix_if.pix_data  = 8'h00;
        pix_if.pix_last  = 1'b0;
        threshold        = 8'd128;
        result_in        = 16'h0000;
        repeat (2) @(negedge clk);
        checkOutput("reset_out_we",       32'(out_we),         32'd0);
        checkOutput("reset_out_byte",     32'(out_byte),       32'd0);
        checkOutput("reset_result",       32'(result),         32'd0);
        checkOutput("reset_result_valid", 32'(result_valid),   32'd0);
        checkOutput("reset_frame_error",  32'(frame_error),    32'd0);
        checkOutput("reset_pix_ready",    32'(pix_if.pix_ready), 32'd1);
        checkOutput("reset_busy",         32'(busy),           32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] nominal frame");
        check_spacing = 1;
        nominal_frame(16'h5A3F);
        end_frame("nominal", 98, 1, 0, 2);
        check_spacing = 0;

        $display("[TB] table-driven threshold and packing frame");
        result_in = 16'h1234;
        res_q.push_back(16'h1234);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].pix, vecs[i].thr, vecs[i].exp, 1'b0);
        end
        for (int b = 0; b < 90; b++) begin
            applyStimulus(64'h0, 8'd1, 8'h00, b == 89);
        end
        end_frame("table", 98, 1, 0, 2);
        checkOutput("table_result_hold", 32'(result), 32'h1234);

        $display("[TB] early last");
        for (int b = 0; b < 12; b++) begin
            applyStimulus(64'hC80AC80AC80AC80A, 8'd128, 8'hAA, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            send_pixel(8'd200, 8'd128, i == 3);
        end
        end_frame("early_last", 12, 0, 1, 0);
        checkOutput("early_last_result_hold", 32'(result), 32'h1234);
        nominal_frame(16'h0C0D);
        end_frame("after_early", 98, 1, 0, 2);

        $display("[TB] missing last");
        for (int b = 0; b < 98; b++) begin
            applyStimulus(64'hC80AC80AC80AC80A, 8'd128, 8'hAA, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            send_pixel(8'd200, 8'd128, i == 4);
        end
        end_frame("missing_last", 98, 0, 1, 0);
        checkOutput("missing_last_result_hold", 32'(result), 32'h0C0D);

        $display("[TB] random gaps");
        gaps = 1;
        nominal_frame(16'h7E81);
        end_frame("gaps", 98, 1, 0, 2);
        gaps = 0;

        $display("[TB] reset mid-frame");
        for (int b = 0; b < 50; b++) begin
            applyStimulus(64'hC80AC80AC80AC80A, 8'd128, 8'hAA, 1'b0);
        end
        @(negedge clk);
        checkOutput("pre_reset_writes", 32'(we_count), 32'd50);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_we",       32'(out_we),           32'd0);
        checkOutput("midreset_out_byte",     32'(out_byte),         32'd0);
        checkOutput("midreset_result",       32'(result),           32'd0);
        checkOutput("midreset_result_valid", 32'(result_valid),     32'd0);
        checkOutput("midreset_frame_error",  32'(frame_error),      32'd0);
        checkOutput("midreset_busy",         32'(busy),             32'd0);
        checkOutput("midreset_pix_ready",    32'(pix_if.pix_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_counters();
        @(negedge clk);
        nominal_frame(16'hBEEF);
        end_frame("after_reset", 98, 1, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lgn_frame_loader.md
LGN_FRAME_LOADER -- requirements
Module: lgn_frame_loader

Interface
REQ-001 The block SHALL have parameter PIXELS, default 784, giving pixels per frame; it must be a multiple of 8.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 2, giving the wait in cycles between the last byte write and result capture; its range is 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state changing on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port pix_valid, input, 1 bit: a grayscale pixel is offered.
REQ-006 The block SHALL have port pix_ready, output, 1 bit: the block can accept a pixel; a pixel is accepted on a cycle where pix_valid and pix_ready are both high.
REQ-007 The block SHALL have port pix_data, input, 8 bits: unsigned grayscale value.
REQ-008 The block SHALL have port pix_last, input, 1 bit: marks the final pixel of a frame.
REQ-009 The block SHALL have port threshold, input, 8 bits: the binarization level, sampled at each acceptance.
REQ-010 The block SHALL have port out_byte, output, 8 bits: a packed pixel byte, which drives the classifier ui_in.
REQ-011 The block SHALL have port out_we, output, 1 bit: a one-cycle write strobe, which drives the classifier write_enable.
REQ-012 The block SHALL have port result_in, input, 16 bits: the classifier's combinational uo_out.
REQ-013 The block SHALL have port result, output, 16 bits: the captured classifier output.
REQ-014 The block SHALL have port result_valid, output, 1 bit: a one-cycle pulse marking a new result.
REQ-015 The block SHALL have port frame_error, output, 1 bit: a one-cycle pulse marking a malformed frame.
REQ-016 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 The state machine SHALL have four states: IDLE, LOAD, SKIP and SETTLE.
REQ-018 pix_ready SHALL be 1 in IDLE, LOAD and SKIP, and 0 in SETTLE.
REQ-019 Each accepted pixel in IDLE or LOAD SHALL be binarized as bit = (pix_data >= threshold), an unsigned comparison.
REQ-020 Bits SHALL be packed MSB-first: the first pixel of each group of 8 lands in out_byte[7] and the 8th in out_byte[0].
REQ-021 A 10-bit pixel counter SHALL count accepted pixels 0..PIXELS-1; it is cleared in IDLE and on every return to IDLE.
REQ-022 On acceptance of every 8th pixel (counter[2:0]==7), out_we SHALL be 1 in the next cycle, with out_byte holding the completed byte; out_we is 0 at all other times.
REQ-023 out_byte SHALL hold its value between strobes.
REQ-024 Consecutive bytes SHALL be written back-to-back when pixels arrive every cycle, giving a full throughput of one pixel per cycle.
REQ-025 In IDLE, an accepted pixel SHALL be processed as pixel 0 and move the machine to LOAD; if it also carries pix_last, the case is treated as an early last (REQ-027).
REQ-026 Acceptance of pixel PIXELS-1 with pix_last=1 SHALL move the machine to SETTLE.
REQ-027 Acceptance of pix_last with counter < PIXELS-1 (early last) SHALL pulse frame_error next cycle, discard the partial byte (no out_we), and return to IDLE with no result.
REQ-028 Acceptance of pixel PIXELS-1 with pix_last=0 SHALL still write its byte, pulse frame_error next cycle, and enter SKIP.
REQ-029 In SKIP, pixels SHALL be accepted and dropped with no out_we; acceptance of pix_last returns the machine to IDLE, and no result is produced.
REQ-030 In SETTLE, a 4-bit counter SHALL count SETTLE_CYCLES cycles starting the cycle after the final out_we.
REQ-031 On the SETTLE_CYCLES-th cycle, result SHALL capture result_in, result_valid pulses 1 in the following cycle, and the machine returns to IDLE.
REQ-032 result SHALL hold its value until the next capture and is unchanged by frame errors.
REQ-033 threshold changes mid-frame SHALL take effect on the next accepted pixel.
REQ-034 pix_data, threshold and pix_last SHALL be ignored when no acceptance occurs.

Reset
REQ-035 While rst_n=0, the block SHALL be in IDLE with both counters at 0, out_byte=0, out_we=0, result=0, result_valid=0 and frame_error=0, pix_ready=1 and busy=0.
REQ-036 Reset asserted mid-LOAD or mid-SETTLE SHALL abort the frame immediately, issue no further out_we, leave result at 0, and is not flagged as frame_error.

Verification
REQ-037 The bench SHALL cover the nominal frame: threshold=128, 784 pixels back-to-back alternating 200,10 with pix_last on the last pixel -> 98 out_we pulses of 0xAA on consecutive 8-cycle boundaries, then a SETTLE of 2 cycles, result=result_in value (e.g. 0x5A3F), and a single result_valid pulse.
REQ-038 The bench SHALL cover the threshold boundary: pix_data=127 and 128 with threshold=128 -> bits 0 and 1; the first byte of 128,127,127,127,127,127,127,127 yields out_byte=0x80.
REQ-039 The bench SHALL cover an early last: pix_last on pixel 100 (index 99) -> 12 out_we pulses, frame_error pulse, no result_valid, busy=0; a following good frame classifies normally.
REQ-040 The bench SHALL cover a missing last: 784 pixels without pix_last, then 5 more with pix_last on the 5th -> 98 writes, frame_error, 5 pixels dropped, no result_valid, and a return to IDLE.
REQ-041 The bench SHALL cover backpressure and gaps: pix_valid randomly deasserted at 50% -> identical byte sequence to the nominal frame; pix_ready stays 0 for exactly 2 cycles in SETTLE.
REQ-042 The bench SHALL cover reset mid-frame: rst_n pulsed low after 400 pixels -> all outputs at reset values asynchronously, and the next full frame produces exactly 98 writes and one result_valid.
